apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master.sv | 125 ++++++++++++
 tb/tb_apb_cmd_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB master that turns a command/response handshake into single APB transfers,
// one outstanding at a time, aborting a stalled slave after TIMEOUT wait cycles.
module apb_cmd_master #(
  parameter int AWID    = 16,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AWID-1:0] cmd_addr,
  input  logic [31:0]     cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_timeout,
  output logic [AWID-1:0] apb_addr,
  output logic            apb_selx,
  output logic            apb_enable,
  output logic            apb_write,
  output logic [31:0]     apb_wdata,
  input  logic            apb_ready,
  input  logic [31:0]     apb_rdata,
  input  logic            apb_slverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_wait_cnt;
  logic            r_cmd_ready;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;
  logic            r_rsp_timeout;
  logic [AWID-1:0] r_addr;
  logic            r_selx;
  logic            r_enable;
  logic            r_write;
  logic [31:0]     r_wdata;

  // Every output is a flop updated alongside the state, so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wait_cnt    <= 8'd0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'd0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_addr        <= '0;
      r_selx        <= 1'b0;
      r_enable      <= 1'b0;
      r_write       <= 1'b0;
      r_wdata       <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_addr;
            r_write     <= cmd_write;
            r_wdata     <= cmd_wdata;
            r_wait_cnt  <= 8'd0;
            r_cmd_ready <= 1'b0;
            r_selx      <= 1'b1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_enable <= 1'b1;
          r_state  <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over the timeout when both land in the same cycle.
          if (apb_ready) begin
            r_rsp_rdata   <= r_write ? 32'd0 : apb_rdata;
            r_rsp_err     <= apb_slverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_selx        <= 1'b0;
            r_enable      <= 1'b0;
            r_state       <= RESP;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_rsp_rdata   <= 32'd0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_selx        <= 1'b0;
            r_enable      <= 1'b0;
            r_state       <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign apb_addr    = r_addr;
  assign apb_selx    = r_selx;
  assign apb_enable  = r_enable;
  assign apb_write   = r_write;
  assign apb_wdata   = r_wdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed scenarios plus randomized transfers
// against a transfer-level model of wait states, slave errors and timeouts.
module tb_apb_cmd_master;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] apb_addr;
  logic        apb_selx;
  logic        apb_enable;
  logic        apb_write;
  logic [31:0] apb_wdata;
  logic        apb_ready = 1'b0;
  logic [31:0] apb_rdata = 32'd0;
  logic        apb_slverr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  apb_cmd_master #(.AWID(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb_addr(apb_addr), .apb_selx(apb_selx), .apb_enable(apb_enable),
    .apb_write(apb_write), .apb_wdata(apb_wdata),
    .apb_ready(apb_ready), .apb_rdata(apb_rdata), .apb_slverr(apb_slverr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One full transfer. The slave raises apb_ready on ACCESS cycle number 'waits'
  // (counting from 0); waits >= TMO means the slave never answers in time.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input logic se, input int bp);
    int          acc;
    bit          done;
    int          exp_acc;
    logic        exp_to;
    logic        exp_er;
    logic [31:0] exp_rd;
    exp_to  = (waits >= TMO);
    exp_acc = exp_to ? TMO : waits + 1;
    exp_er  = exp_to | se;
    exp_rd  = (wr | exp_to) ? 32'd0 : rd;

    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL idle_cmd_ready got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; rsp_ready = 1'b0;
    apb_ready = 1'($urandom); apb_rdata = $urandom; apb_slverr = 1'($urandom);

    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = $urandom;
    n_cmp++;
    if ({apb_selx, apb_enable, apb_write, apb_addr, apb_wdata} !== {1'b1, 1'b0, wr, addr, wd}) begin
      n_err++;
      $display("[TB] FAIL setup_phase got sel=%b en=%b wr=%b a=%h d=%h want sel=1 en=0 wr=%b a=%h d=%h",
               apb_selx, apb_enable, apb_write, apb_addr, apb_wdata, wr, addr, wd);
    end
    apb_ready = 1'($urandom); apb_rdata = $urandom; apb_slverr = 1'($urandom);

    @(negedge clk);
    acc = 0; done = 0;
    while (!done && acc < TMO + 4) begin
      n_cmp++;
      if ({apb_selx, apb_enable, apb_write, apb_addr, apb_wdata} !== {1'b1, 1'b1, wr, addr, wd}) begin
        n_err++;
        $display("[TB] FAIL access_phase cyc %0d got sel=%b en=%b wr=%b a=%h d=%h want sel=1 en=1 wr=%b a=%h d=%h",
                 acc, apb_selx, apb_enable, apb_write, apb_addr, apb_wdata, wr, addr, wd);
      end
      apb_ready  = (acc == waits);
      apb_rdata  = apb_ready ? rd : $urandom;
      apb_slverr = apb_ready ? se : 1'($urandom);
      @(negedge clk);
      acc++;
      if (rsp_valid) done = 1;
    end
    apb_ready = 1'b0;

    n_cmp++;
    if (!done) begin
      n_err++; $display("[TB] FAIL rsp_never_valid after %0d access cycles", acc);
    end
    n_cmp++;
    if (acc != exp_acc) begin
      n_err++; $display("[TB] FAIL access_cycles got %0d want %0d", acc, exp_acc);
    end
    n_cmp++;
    if ({rsp_rdata, rsp_err, rsp_timeout, apb_selx, apb_enable, cmd_ready} !==
        {exp_rd, exp_er, exp_to, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL response got rd=%h err=%b to=%b sel=%b en=%b crdy=%b want rd=%h err=%b to=%b sel=0 en=0 crdy=0",
               rsp_rdata, rsp_err, rsp_timeout, apb_selx, apb_enable, cmd_ready, exp_rd, exp_er, exp_to);
    end

    repeat (bp) begin
      apb_ready = 1'($urandom); apb_rdata = $urandom; apb_slverr = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready} !== {1'b1, exp_rd, exp_er, exp_to, 1'b0}) begin
        n_err++;
        $display("[TB] FAIL rsp_hold got v=%b rd=%h err=%b to=%b crdy=%b want v=1 rd=%h err=%b to=%b crdy=0",
                 rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, exp_rd, exp_er, exp_to);
      end
    end
    apb_ready = 1'b0;

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, apb_selx} !== 3'b010) begin
      n_err++;
      $display("[TB] FAIL rsp_release got v=%b crdy=%b sel=%b want v=0 crdy=1 sel=0", rsp_valid, cmd_ready, apb_selx);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'hBEEF; cmd_wdata = 32'hDEADBEEF;
    apb_ready = 1'b1; apb_rdata = 32'h12345678; apb_slverr = 1'b1; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, apb_addr, apb_selx, apb_enable, apb_write, apb_wdata}
        !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      n_err++;
      $display("[TB] FAIL reset_values got crdy=%b v=%b rd=%h err=%b to=%b a=%h sel=%b en=%b wr=%b d=%h want crdy=1 and all else 0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, apb_addr, apb_selx, apb_enable, apb_write, apb_wdata);
    end
    cmd_valid = 1'b0; apb_ready = 1'b0; apb_slverr = 1'b0; rsp_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, apb_selx} !== 2'b10) begin
      n_err++; $display("[TB] FAIL post_reset_idle got crdy=%b sel=%b want crdy=1 sel=0", cmd_ready, apb_selx);
    end
  endtask

  task automatic test_read_wait;
    run_txn(1'b0, 16'h0004, 32'h0, 1, 32'h20240101, 1'b0, 0);
  endtask

  task automatic test_write_zero_wait;
    run_txn(1'b1, 16'h0010, 32'hA5A5A5A5, 0, 32'hFFFFFFFF, 1'b0, 1);
  endtask

  task automatic test_slverr;
    run_txn(1'b0, 16'h0020, 32'h0, 0, 32'hCAFEF00D, 1'b1, 0);
    run_txn(1'b1, 16'h0024, 32'h11223344, 2, 32'h0, 1'b1, 0);
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 16'h0030, 32'h0, 100, 32'h55555555, 1'b0, 0);
    run_txn(1'b1, 16'h0034, 32'h77777777, TMO - 1, 32'h0, 1'b0, 0);
    run_txn(1'b0, 16'h0038, 32'h0, TMO, 32'h66666666, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100; cmd_wdata = 32'h0; rsp_ready = 1'b0;
    apb_ready = 1'b0;
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 16'h0200; cmd_wdata = 32'h0BADC0DE;
    @(negedge clk);
    apb_ready = 1'b1; apb_rdata = 32'h13572468; apb_slverr = 1'b0;
    @(negedge clk);
    apb_ready = 1'b0;
    repeat (5) begin
      apb_rdata = $urandom; apb_slverr = 1'($urandom);
      n_cmp++;
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, apb_selx, apb_addr}
          !== {1'b1, 32'h13572468, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100}) begin
        n_err++;
        $display("[TB] FAIL bp_hold got v=%b rd=%h err=%b to=%b crdy=%b sel=%b a=%h want v=1 rd=13572468 err=0 to=0 crdy=0 sel=0 a=0100",
                 rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, apb_selx, apb_addr);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, apb_selx} !== 3'b010) begin
      n_err++; $display("[TB] FAIL bp_release got v=%b crdy=%b sel=%b want v=0 crdy=1 sel=0", rsp_valid, cmd_ready, apb_selx);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({apb_selx, apb_enable, apb_write, apb_addr, apb_wdata} !== {1'b1, 1'b0, 1'b1, 16'h0200, 32'h0BADC0DE}) begin
      n_err++;
      $display("[TB] FAIL second_cmd got sel=%b en=%b wr=%b a=%h d=%h want sel=1 en=0 wr=1 a=0200 d=0badc0de",
               apb_selx, apb_enable, apb_write, apb_addr, apb_wdata);
    end
    @(negedge clk);
    apb_ready = 1'b1; apb_rdata = 32'hFFFF0000;
    @(negedge clk);
    apb_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'd0}) begin
      n_err++; $display("[TB] FAIL second_rsp got v=%b rd=%h want v=1 rd=0", rsp_valid, rsp_rdata);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, cmd_ready, apb_selx, apb_enable} !== 4'b0100) begin
      n_err++;
      $display("[TB] FAIL reset_in_resp got v=%b crdy=%b sel=%b en=%b want v=0 crdy=1 sel=0 en=0",
               rsp_valid, cmd_ready, apb_selx, apb_enable);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0300; apb_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({apb_selx, apb_enable, rsp_valid, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("[TB] FAIL reset_in_access got sel=%b en=%b v=%b crdy=%b want sel=0 en=0 v=0 crdy=1",
               apb_selx, apb_enable, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0404; cmd_wdata = 32'h0F0F0F0F;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({apb_selx, apb_enable, apb_addr, apb_wdata} !== {1'b1, 1'b0, 16'h0404, 32'h0F0F0F0F}) begin
      n_err++;
      $display("[TB] FAIL first_edge_accept got sel=%b en=%b a=%h d=%h want sel=1 en=0 a=0404 d=0f0f0f0f",
               apb_selx, apb_enable, apb_addr, apb_wdata);
    end
    @(negedge clk);
    apb_ready = 1'b1;
    @(negedge clk);
    apb_ready = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("[TB] FAIL after_reset_txn got crdy=%b v=%b want crdy=1 v=0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), 16'($urandom), $urandom, int'($urandom_range(0, 6)),
              $urandom, 1'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write_zero_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
